// File: rtl/cache_replace.sv
// Replacement-policy unit: tree-PLRU, LFSR-random or round-robin victim selection with per-set state.
// Optional macro REPL_EVICT_COUNT_EN adds the saturating EvictCount output.
module cache_replace #(
  parameter int NUMWAYS  = 4,
  parameter int NUMLINES = 128,
  parameter int SETLEN   = 7,
  parameter int POLICY   = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               CacheEn,
  input  logic               FlushStage,
  input  logic [NUMWAYS-1:0] HitWay,
  input  logic [NUMWAYS-1:0] ValidWay,
  input  logic [SETLEN-1:0]  CacheSetData,
  input  logic [SETLEN-1:0]  CacheSetTag,
  input  logic               LRUWriteEn,
  input  logic               SetValid,
  input  logic               InvalidateCache,
  output logic [NUMWAYS-1:0] VictimWay,
  output logic               Busy
`ifdef REPL_EVICT_COUNT_EN
  ,
  output logic [31:0]        EvictCount
`endif
);
  localparam int WAYW = $clog2(NUMWAYS);

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} fsm_t;

  fsm_t              fsm_r;
  logic              busy_r;
  logic [SETLEN-1:0] clr_cnt_r;
  logic              wr_acc_s;
  logic [WAYW-1:0]   hit_enc_s;
  logic [WAYW-1:0]   victim_enc_s;
  logic [WAYW-1:0]   pol_victim_s;
  logic [WAYW-1:0]   upd_way_s;

  assign wr_acc_s  = LRUWriteEn & ~FlushStage & ~busy_r;
  assign Busy      = busy_r;
  assign upd_way_s = SetValid ? victim_enc_s : hit_enc_s;
  assign VictimWay = {{(NUMWAYS-1){1'b0}}, 1'b1} << victim_enc_s;

  // Clear sequencer: walks every set once after reset or invalidate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_r     <= CLEAR;
      busy_r    <= 1'b1;
      clr_cnt_r <= '0;
    end else if (InvalidateCache) begin
      fsm_r     <= CLEAR;
      busy_r    <= 1'b1;
      clr_cnt_r <= '0;
    end else begin
      case (fsm_r)
        CLEAR: begin
          if (clr_cnt_r == SETLEN'(NUMLINES - 1)) begin
            fsm_r     <= IDLE;
            busy_r    <= 1'b0;
            clr_cnt_r <= '0;
          end else begin
            clr_cnt_r <= clr_cnt_r + 1'b1;
          end
        end
        IDLE: begin
          fsm_r  <= IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          fsm_r     <= CLEAR;
          busy_r    <= 1'b1;
          clr_cnt_r <= '0;
        end
      endcase
    end
  end

  // One-hot hit vector to way index
  always_comb begin
    hit_enc_s = '0;
    for (int i = 0; i < NUMWAYS; i++) begin
      if (HitWay[i]) hit_enc_s = hit_enc_s | WAYW'(i);
      else           hit_enc_s = hit_enc_s;
    end
  end

  // Lowest invalid way wins over the policy choice
  always_comb begin
    victim_enc_s = pol_victim_s;
    for (int i = NUMWAYS - 1; i >= 0; i--) begin
      if (!ValidWay[i]) victim_enc_s = WAYW'(i);
      else              victim_enc_s = victim_enc_s;
    end
  end

  if (POLICY == 1) begin : g_lfsr
    logic [15:0] lfsr_r;

    // Global LFSR steps only on accepted fills
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        lfsr_r <= 16'h0001;
      end else if (wr_acc_s && SetValid) begin
        lfsr_r <= {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
      end
    end

    assign pol_victim_s = lfsr_r[WAYW-1:0];
  end else begin : g_state
    localparam int SW = (POLICY == 0) ? NUMWAYS - 1 : WAYW;

    logic [SW-1:0] mem_r [NUMLINES];
    logic [SW-1:0] curr_state_r;
    logic [SW-1:0] next_state_s;

    // State array: clear sequencer has priority over user updates
    always_ff @(posedge clk) begin
      if (busy_r) begin
        mem_r[clr_cnt_r] <= '0;
      end else if (wr_acc_s) begin
        mem_r[CacheSetTag] <= next_state_s;
      end
    end

    // Registered read with write-first bypass on a same-set update
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        curr_state_r <= '0;
      end else if (busy_r) begin
        curr_state_r <= '0;
      end else if (CacheEn) begin
        if (wr_acc_s && (CacheSetData == CacheSetTag)) curr_state_r <= next_state_s;
        else                                           curr_state_r <= mem_r[CacheSetData];
      end
    end

    if (POLICY == 0) begin : g_plru
      // Heap-ordered tree: bit 0 steers left, leaves start at node NUMWAYS-1
      always_comb begin
        int node;
        node = 0;
        for (int lvl = 0; lvl < WAYW; lvl++) begin
          node = 2 * node + 1 + int'(curr_state_r[node]);
        end
        pol_victim_s = WAYW'(node - (NUMWAYS - 1));
      end

      // Path nodes of the updated way are pointed away from it
      always_comb begin
        int node;
        next_state_s = curr_state_r;
        node = 0;
        for (int lvl = 0; lvl < WAYW; lvl++) begin
          next_state_s[node] = ~upd_way_s[WAYW-1-lvl];
          node = 2 * node + 1 + int'(upd_way_s[WAYW-1-lvl]);
        end
      end
    end else begin : g_rr
      assign pol_victim_s = curr_state_r;
      assign next_state_s = SetValid ? upd_way_s + 1'b1 : curr_state_r;
    end
  end

`ifdef REPL_EVICT_COUNT_EN
  logic [31:0] evict_cnt_r;

  // Counts replacements of a valid line, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evict_cnt_r <= 32'd0;
    end else if (InvalidateCache) begin
      evict_cnt_r <= 32'd0;
    end else if (wr_acc_s && SetValid && (&ValidWay) && (evict_cnt_r != 32'hFFFFFFFF)) begin
      evict_cnt_r <= evict_cnt_r + 32'd1;
    end
  end

  assign EvictCount = evict_cnt_r;
`endif

endmodule

// File: doc/cache_replace.md
Name: cache_replace

Overview:
Parametrised replacement-policy unit for the L1 I$/D$ cache, selecting tree-PLRU, LFSR-random or per-set round-robin victims via POLICY. Holds per-set replacement state in an internal array with a registered read and a self-clearing invalidate sequencer. Fills go to the lowest-index invalid way before the policy choice applies. Sits beside the tag/data arrays and drives VictimWay to the cache FSM.

Parameters:
NUMWAYS, 4, associativity; power of 2, 2..128
NUMLINES, 128, sets per way
SETLEN, 7, set index width, = log2(NUMLINES)
POLICY, 0, 0 = tree-PLRU, 1 = LFSR random, 2 = round-robin

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
CacheEn  in  1  enables state-array read; 0 holds CurrState
FlushStage  in  1  suppresses state writes this cycle
HitWay  in  NUMWAYS  one-hot hit way
ValidWay  in  NUMWAYS  valid bits of the addressed set
CacheSetData  in  SETLEN  set index for the state read
CacheSetTag  in  SETLEN  set index for the state write, aligned with CurrState
LRUWriteEn  in  1  update state of set CacheSetTag
SetValid  in  1  this update is a fill; use victim, not HitWay
InvalidateCache  in  1  clear all replacement state
VictimWay  out  NUMWAYS  one-hot victim
Busy  out  1  clear sequence in progress

Behaviour:
- State width SW: PLRU NUMWAYS-1 bits, RR log2(NUMWAYS) bits, LFSR 0 (no array).
- Read: when CacheEn, CurrState <= array[CacheSetData]; 1-cycle latency. When ~CacheEn, CurrState holds.
- Write: when LRUWriteEn & ~FlushStage & ~Busy, array[CacheSetTag] <= NextState. If the same cycle has CacheEn and CacheSetData == CacheSetTag, CurrState captures NextState (write-first bypass).
- UpdWay = SetValid ? encoded VictimWay : encoded HitWay.
- PLRU: heap-indexed tree, root node 0, children of node i are 2i+1/2i+2, leaves map to ways 0..NUMWAYS-1 left to right. Victim: from root, bit 0 -> left, 1 -> right. Update: each node on UpdWay's path is set to point away from UpdWay; off-path nodes keep their value.
- LFSR: one global 16-bit Fibonacci register. Next = {s0^s2^s3^s5, s[15:1]}. Reset value 16'h0001. Advances only on an accepted write with SetValid. Policy victim = s[log2(NUMWAYS)-1:0].
- RR: victim = per-set pointer. Accepted write with SetValid sets the pointer to victim+1 mod NUMWAYS, wrapping from NUMWAYS-1 to 0. Hits leave it unchanged.
- VictimWay (combinational from CurrState/ValidWay/LFSR): if ValidWay is not all-ones, it is the lowest-index zero in ValidWay; otherwise the policy victim.
- FSM: IDLE and CLEAR.
  - reset asserted -> CLEAR, ClrCnt = 0.
  - CLEAR: writes 0 to array[ClrCnt] each cycle and increments ClrCnt. After writing set NUMLINES-1 -> IDLE.
  - IDLE: InvalidateCache -> CLEAR with ClrCnt = 0. InvalidateCache during CLEAR restarts ClrCnt at 0.
  - Busy = (state == CLEAR). User writes are dropped while Busy. CurrState reads 0 while Busy.
- Reset values: Busy = 1, CurrState = 0, LFSR = 16'h0001, RR pointers 0 after clear. VictimWay after reset with all ways valid: PLRU way 0, RR way 0, LFSR way 1.
- Reset mid-CLEAR restarts the sequence at set 0. Reset mid-write discards the write.

Optional Feature:
REPL_EVICT_COUNT_EN: adds output EvictCount [31:0]. It increments on each accepted write with SetValid while ValidWay is all-ones, saturates at 32'hFFFFFFFF, and is cleared by reset and by InvalidateCache. When the macro is undefined, the port and counter are absent and all other behaviour is identical.

Test Plan:
- Reset deassert, NUMLINES = 128 -> Busy high exactly 128 cycles, then 0; every set reads state 0.
- PLRU, NUMWAYS = 4, all valid, set 5: hit updates way 0 then way 2 -> VictimWay = 4'b0010. Further hits on ways 0, 1, 2 -> VictimWay = 4'b0001.
- RR, 4-way, all valid: five fills on set 3 -> victims 0, 1, 2, 3, 0 (wrap). Set 4 victim stays way 0.
- LFSR, 4-way, all valid: first fill victim way 1 (LFSR 0x0001), second fill victim way 0 (LFSR 0x8000). Hits do not advance the LFSR.
- ValidWay = 4'b1011 under any policy -> VictimWay = 4'b0100. Write with FlushStage = 1 -> state unchanged next read. Same-set read/write -> CurrState shows the new value the next cycle.
- InvalidateCache mid-sequence plus LRUWriteEn during Busy -> write dropped, 128-cycle clear restarts. With REPL_EVICT_COUNT_EN: 3 all-valid fills -> EvictCount = 3, cleared to 0 by the invalidate.
